// File: rtl/predecode_queue.sv
// Fetch-to-issue instruction queue that pre-decodes branch class, link and HI/LO use on enqueue.
// Optional PREDECODE_DELAY_SLOT_EN holds back a branch until its delay slot is presented alongside it.
module predecode_queue #(
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned IN_WIDTH  = 2,
  parameter int unsigned OUT_WIDTH = 2
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             flush,
  input  logic [$clog2(IN_WIDTH+1)-1:0]    in_count,
  input  logic [IN_WIDTH*32-1:0]           in_instr,
  input  logic [IN_WIDTH*32-1:0]           in_pc,
  output logic                             in_ready,
  output logic [OUT_WIDTH-1:0]             out_valid,
  output logic [OUT_WIDTH*32-1:0]          out_instr,
  output logic [OUT_WIDTH*32-1:0]          out_pc,
  output logic [OUT_WIDTH*3-1:0]           out_branch_type,
  output logic [OUT_WIDTH-1:0]             out_is_branch,
  output logic [OUT_WIDTH-1:0]             out_is_link,
  output logic [OUT_WIDTH-1:0]             out_is_hilo,
  input  logic [$clog2(OUT_WIDTH+1)-1:0]   out_accept,
  output logic [$clog2(DEPTH+1)-1:0]       occupancy
);

  localparam int unsigned PW  = $clog2(DEPTH);
  localparam int unsigned OCW = $clog2(DEPTH+1);

  typedef enum logic [2:0] {
    B_INVA = 3'd0,
    B_EQNE = 3'd1,
    B_LTGE = 3'd2,
    B_JUMP = 3'd3,
    B_JREG = 3'd4
  } branch_type_e;

  typedef struct packed {
    logic [31:0]  instr;
    logic [31:0]  pc;
    branch_type_e btype;
    logic         link;
    logic         hilo;
  } entry_t;

  entry_t         mem_q [DEPTH];
  entry_t         mem_d [DEPTH];
  logic [PW-1:0]  head_q, head_d, tail_q, tail_d;
  logic [OCW-1:0] occ_q, occ_d;
  logic [OCW-1:0] enq_cnt;

  function automatic entry_t predecode(input logic [31:0] instr, input logic [31:0] pc);
    entry_t     e;
    logic [5:0] op;
    logic [5:0] funct;
    logic [4:0] rt;
    op      = instr[31:26];
    rt      = instr[20:16];
    funct   = instr[5:0];
    e.instr = instr;
    e.pc    = pc;
    e.btype = B_INVA;
    e.link  = 1'b0;
    if (op[5:2] == 4'b0001) begin
      e.btype = B_EQNE;
    end else if (op == 6'b000001 && rt[3:1] == 3'b000) begin
      e.btype = B_LTGE;
      e.link  = rt[4];
    end else if (op[5:1] == 5'b00001) begin
      e.btype = B_JUMP;
      e.link  = op[0];
    end else if (op == 6'b000000 && funct[5:1] == 5'b00100) begin
      e.btype = B_JREG;
      e.link  = funct[0];
    end
    e.hilo = (op == 6'b000000 && (funct[5:2] == 4'b0100 || funct[5:2] == 4'b0110)) ||
             (op == 6'b011100 && funct[5:3] == 3'b000 &&
              (funct[2:0] == 3'd0 || funct[2:0] == 3'd1 || funct[2:0] == 3'd2 ||
               funct[2:0] == 3'd4 || funct[2:0] == 3'd5));
    return e;
  endfunction

  // in_ready looks only at the registered occupancy, never at same-cycle frees.
  assign in_ready  = (occ_q <= OCW'(DEPTH - IN_WIDTH));
  assign occupancy = occ_q;

  always_comb begin
    mem_d   = mem_q;
    head_d  = head_q;
    tail_d  = tail_q;
    occ_d   = occ_q;
    enq_cnt = in_ready ? OCW'(in_count) : '0;
    if (flush) begin
      head_d = '0;
      tail_d = '0;
      occ_d  = '0;
    end else begin
      for (int unsigned i = 0; i < IN_WIDTH; i++) begin
        if (OCW'(i) < enq_cnt) begin
          mem_d[tail_q + PW'(i)] = predecode(in_instr[i*32 +: 32], in_pc[i*32 +: 32]);
        end
      end
      tail_d = tail_q + PW'(enq_cnt);
      head_d = head_q + PW'(out_accept);
      occ_d  = occ_q + enq_cnt - OCW'(out_accept);
    end
  end

  always_comb begin
`ifdef PREDECODE_DELAY_SLOT_EN
    logic blocked;
    blocked = 1'b0;
`endif
    out_valid       = '0;
    out_instr       = '0;
    out_pc          = '0;
    out_branch_type = '0;
    out_is_branch   = '0;
    out_is_link     = '0;
    out_is_hilo     = '0;
    for (int unsigned i = 0; i < OUT_WIDTH; i++) begin
      out_instr[i*32 +: 32]     = mem_q[head_q + PW'(i)].instr;
      out_pc[i*32 +: 32]        = mem_q[head_q + PW'(i)].pc;
      out_branch_type[i*3 +: 3] = mem_q[head_q + PW'(i)].btype;
      out_is_branch[i]          = mem_q[head_q + PW'(i)].btype != B_INVA;
      out_is_link[i]            = mem_q[head_q + PW'(i)].link;
      out_is_hilo[i]            = mem_q[head_q + PW'(i)].hilo;
`ifdef PREDECODE_DELAY_SLOT_EN
      // Once a branch lacks its slot lane, it and every younger lane stay invalid.
      if (OCW'(i) < occ_q && mem_q[head_q + PW'(i)].btype != B_INVA &&
          (i + 1 >= OUT_WIDTH || OCW'(i + 1) >= occ_q)) begin
        blocked = 1'b1;
      end
      out_valid[i] = (OCW'(i) < occ_q) && !blocked;
`else
      out_valid[i] = (OCW'(i) < occ_q);
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q <= '0;
      tail_q <= '0;
      occ_q  <= '0;
      mem_q  <= '{default: '0};
    end else begin
      head_q <= head_d;
      tail_q <= tail_d;
      occ_q  <= occ_d;
      mem_q  <= mem_d;
    end
  end

  accept_le_valid: assert property (@(posedge clk) disable iff (rst)
    int'(out_accept) <= $countones(out_valid));

endmodule

// File: tb/tb_predecode_queue.sv
// Randomised bench for predecode_queue against a queue-based reference model.
module tb_predecode_queue;
  localparam int DEPTH = 8;
  localparam int IW    = 2;
  localparam int OW    = 2;
  localparam logic [2:0] T_INVA = 3'd0, T_EQNE = 3'd1, T_LTGE = 3'd2, T_JUMP = 3'd3, T_JREG = 3'd4;

  logic        clk = 1'b0;
  logic        rst, flush;
  logic [1:0]  in_count;
  logic [63:0] in_instr, in_pc;
  logic        in_ready;
  logic [1:0]  out_valid;
  logic [63:0] out_instr, out_pc;
  logic [5:0]  out_branch_type;
  logic [1:0]  out_is_branch, out_is_link, out_is_hilo;
  logic [1:0]  out_accept;
  logic [3:0]  occupancy;

  predecode_queue #(.DEPTH(DEPTH), .IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_count(in_count), .in_instr(in_instr),
    .in_pc(in_pc), .in_ready(in_ready), .out_valid(out_valid), .out_instr(out_instr),
    .out_pc(out_pc), .out_branch_type(out_branch_type), .out_is_branch(out_is_branch),
    .out_is_link(out_is_link), .out_is_hilo(out_is_hilo), .out_accept(out_accept),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] instr; logic [31:0] pc; } ent_t;
  ent_t        mq[$];
  logic [31:0] pc_ctr;
  int          n_cmp = 0;
  int          n_mis = 0;

  logic [31:0] pool [12] = '{32'h10220003, 32'h0C000010, 32'h0040F809, 32'h04110004,
                             32'h00430018, 32'h70430000, 32'h00001010, 32'h00000000,
                             32'h03E00008, 32'h04000002, 32'h00400013, 32'h70000002};

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Returns {type[2:0], is_branch, link, hilo} from opcode/funct tables.
  function automatic logic [5:0] ref_dec(input logic [31:0] ins);
    int op, rt, fn;
    logic [2:0] t;
    logic lk, hl;
    op = int'(ins[31:26]);
    rt = int'(ins[20:16]);
    fn = int'(ins[5:0]);
    t = T_INVA;
    lk = 1'b0;
    if (op inside {4, 5, 6, 7}) t = T_EQNE;
    else if (op == 1 && rt inside {0, 1, 16, 17}) begin t = T_LTGE; lk = (rt >= 16); end
    else if (op inside {2, 3}) begin t = T_JUMP; lk = (op == 3); end
    else if (op == 0 && fn inside {8, 9}) begin t = T_JREG; lk = (fn == 9); end
    hl = (op == 0 && fn inside {[16:19], [24:27]}) || (op == 28 && fn inside {0, 1, 2, 4, 5});
    return {t, (t != T_INVA), lk, hl};
  endfunction

  function automatic int exp_vcnt();
    int n;
    n = (mq.size() < OW) ? mq.size() : OW;
`ifdef PREDECODE_DELAY_SLOT_EN
    for (int j = 0; j < n; j++) begin
      logic [5:0] d;
      d = ref_dec(mq[j].instr);
      if (d[2] && j + 1 >= n) return j;
    end
`endif
    return n;
  endfunction

  task automatic check_state();
    int vc;
    vc = exp_vcnt();
    chk("occupancy", 64'(occupancy), 64'(mq.size()));
    chk("in_ready", 64'(in_ready), 64'((DEPTH - mq.size()) >= IW));
    chk("out_valid", 64'(out_valid), 64'((1 << vc) - 1));
    for (int i = 0; i < vc; i++) begin
      logic [5:0] d;
      d = ref_dec(mq[i].instr);
      chk("out_instr", 64'(out_instr[i*32 +: 32]), 64'(mq[i].instr));
      chk("out_pc", 64'(out_pc[i*32 +: 32]), 64'(mq[i].pc));
      chk("branch_type", 64'(out_branch_type[i*3 +: 3]), 64'(d[5:3]));
      chk("is_branch", 64'(out_is_branch[i]), 64'(d[2]));
      chk("is_link", 64'(out_is_link[i]), 64'(d[1]));
      chk("is_hilo", 64'(out_is_hilo[i]), 64'(d[0]));
    end
  endtask

  task automatic cycle(input logic f, input int cnt, input int acc,
                       input logic [31:0] i0, input logic [31:0] i1);
    logic [31:0] li [2];
    bit ready;
    flush      = f;
    in_count   = cnt[1:0];
    out_accept = acc[1:0];
    in_instr   = {i1, i0};
    in_pc      = {pc_ctr + 32'd4, pc_ctr};
    li[0] = i0;
    li[1] = i1;
    if (f) mq.delete();
    else begin
      ready = (DEPTH - mq.size()) >= IW;
      for (int k = 0; k < acc; k++) void'(mq.pop_front());
      if (ready) for (int k = 0; k < cnt; k++) mq.push_back('{li[k], pc_ctr + 32'(4 * k)});
    end
    pc_ctr += 32'd8;
    @(posedge clk);
    #1;
    check_state();
  endtask

  task automatic do_reset(input int cnt);
    rst = 1'b1;
    flush = 1'b0;
    in_count = cnt[1:0];
    out_accept = '0;
    in_instr = {32'h0C000010, 32'h00000020};
    in_pc = '0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    in_count = '0;
    mq.delete();
    chk("rst_occupancy", 64'(occupancy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_instr", out_instr, 64'd0);
    chk("rst_out_pc", out_pc, 64'd0);
  endtask

  initial begin
    pc_ctr = 32'h100;
    do_reset(0);

    // BEQ alone, then its delay slot
    cycle(0, 1, 0, 32'h10220003, 32'h0);
`ifdef PREDECODE_DELAY_SLOT_EN
    chk("t1_valid", 64'(out_valid), 64'b00);
`else
    chk("t1_valid", 64'(out_valid), 64'b01);
`endif
    chk("t1_type", 64'(out_branch_type[2:0]), 64'(T_EQNE));
    chk("t1_branch", 64'(out_is_branch[0]), 64'd1);
    chk("t1_link", 64'(out_is_link[0]), 64'd0);
    chk("t1_pc", 64'(out_pc[31:0]), 64'h100);
    cycle(0, 1, 0, 32'h00000000, 32'h0);
    chk("t6_valid", 64'(out_valid), 64'b11);
    cycle(0, 0, 2, 32'h0, 32'h0);

    cycle(0, 2, 0, 32'h0C000010, 32'h0040F809);
    chk("t2_type0", 64'(out_branch_type[2:0]), 64'(T_JUMP));
    chk("t2_link0", 64'(out_is_link[0]), 64'd1);
    chk("t2_type1", 64'(out_branch_type[5:3]), 64'(T_JREG));
    chk("t2_link1", 64'(out_is_link[1]), 64'd1);
    cycle(1, 0, 0, 32'h0, 32'h0);

    cycle(0, 2, 0, 32'h04110004, 32'h00430018);
    chk("t3_type0", 64'(out_branch_type[2:0]), 64'(T_LTGE));
    chk("t3_link0", 64'(out_is_link[0]), 64'd1);
    chk("t3_hilo1", 64'(out_is_hilo[1]), 64'd1);
    cycle(0, 2, 2, 32'h70430000, 32'h00001010);
    chk("t3_hilo", 64'(out_is_hilo), 64'b11);

    // Fill to DEPTH, then wrap the pointers while full-ish
    cycle(1, 0, 0, 32'h0, 32'h0);
    for (int k = 0; k < 4; k++) cycle(0, 2, 0, 32'h00000020 + 32'(k), 32'h00000024);
    chk("t4_full_occ", 64'(occupancy), 64'd8);
    chk("t4_full_ready", 64'(in_ready), 64'd0);
    cycle(0, 2, 2, 32'h00000025, 32'h00000026);
    chk("t4_drop_occ", 64'(occupancy), 64'd6);
    for (int k = 0; k < 3; k++) cycle(0, 2, 2, 32'h00000027, 32'h0000002A);
    chk("t4_wrap_occ", 64'(occupancy), 64'd6);
    for (int k = 0; k < 3; k++) cycle(0, 0, 2, 32'h0, 32'h0);

    cycle(1, 0, 0, 32'h0, 32'h0);
    cycle(0, 2, 0, 32'h20, 32'h21);
    cycle(0, 2, 0, 32'h22, 32'h23);
    cycle(0, 1, 0, 32'h24, 32'h25);
    chk("t5_occ5", 64'(occupancy), 64'd5);
    cycle(1, 2, 1, 32'h26, 32'h27);
    chk("t5_flush_occ", 64'(occupancy), 64'd0);
    chk("t5_flush_valid", 64'(out_valid), 64'b00);

    cycle(0, 2, 0, 32'h20, 32'h21);
    cycle(0, 2, 0, 32'h22, 32'h23);
    do_reset(2);

    for (int c = 0; c < 2000; c++) begin
      logic [31:0] a, b;
      a = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 11)];
      b = ($urandom_range(0, 3) == 0) ? $urandom() : pool[$urandom_range(0, 11)];
      cycle(($urandom_range(0, 31) == 0), $urandom_range(0, 2), $urandom_range(0, exp_vcnt()), a, b);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end
endmodule
